// File: rtl/lane_deskew_pkg.sv
// Shared widths and FSM state type for the lane deskew block.
package lane_deskew_pkg;

  localparam int LANE_W = 8;
  // One bit wider than a delay needs so the counter can exceed MAX_SKEW=7.
  localparam int SKEW_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/lane_deskew_delay_line.sv
// lane_delay_line: per-lane shift register of DEPTH data/valid taps with a
// selectable output tap; tap 0 is the input registered once.
module lane_delay_line
  import lane_deskew_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data,
  input  logic [SKEW_W-1:0] sel,
  output logic              tap0_valid,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data
);

  logic [DEPTH-1:0]  valid_q;
  logic [LANE_W-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  // Compare-based select keeps out-of-range sel values harmless (reads zero).
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel == SKEW_W'(k)) begin
        out_valid = valid_q[k];
        out_data  = data_q[k];
      end
    end
  end

  assign tap0_valid = valid_q[0];

endmodule

// File: rtl/lane_deskew.sv
// lane_deskew: measures inter-lane arrival skew, then delays early lanes so
// every output word carries the same byte index from all lanes.
// Optional LANE_DESKEW_STATS_EN adds saturating lock/error counters.
//
// state   | meaning
// IDLE    | waiting for the first lane valid rising edge
// ACQUIRE | counting skew, recording each lane's arrival
// LOCKED  | delays applied, aligned words emitted
// DRAIN   | after an error, waiting for all raw lane valids low
module lane_deskew
  import lane_deskew_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int MAX_SKEW  = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_LANES-1:0]        lane_valid,
  input  logic [LANE_W*NUM_LANES-1:0] lane_data,
  output logic [LANE_W*NUM_LANES-1:0] word_out,
  output logic                        word_valid,
  output logic                        locked,
  output logic                        align_err
`ifdef LANE_DESKEW_STATS_EN
  ,
  output logic [15:0]                 lock_count,
  output logic [15:0]                 err_count
`endif
);

  localparam int                DEPTH    = MAX_SKEW + 1;
  localparam logic [SKEW_W-1:0] SKEW_LIM = SKEW_W'(MAX_SKEW);

  state_t                      state;
  logic [SKEW_W-1:0]           skew_cnt;
  logic [NUM_LANES-1:0]        rec_q;
  logic [SKEW_W-1:0]           arr_q   [NUM_LANES];
  logic [SKEW_W-1:0]           delay_q [NUM_LANES];

  logic [NUM_LANES-1:0]        tap0_valid;
  logic [NUM_LANES-1:0]        dly_valid;
  logic [LANE_W*NUM_LANES-1:0] dly_data;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_delay_line #(.DEPTH(DEPTH)) u_dl (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (lane_valid[g]),
      .in_data    (lane_data[g*LANE_W +: LANE_W]),
      .sel        (delay_q[g]),
      .tap0_valid (tap0_valid[g]),
      .out_valid  (dly_valid[g]),
      .out_data   (dly_data[g*LANE_W +: LANE_W])
    );
  end

  logic [NUM_LANES-1:0] rise;
  logic [NUM_LANES-1:0] rec_base;
  logic [NUM_LANES-1:0] rec_next;
  logic [SKEW_W-1:0]    cur_cnt;
  logic [SKEW_W-1:0]    max_arr;
  logic [SKEW_W-1:0]    arr_next [NUM_LANES];
  logic [SKEW_W-1:0]    dly_next [NUM_LANES];

  // Arrival of a lane rising this cycle is the current skew count (0 in IDLE);
  // only a lane not yet recorded takes a new arrival.
  always_comb begin
    rise     = lane_valid & ~tap0_valid;
    rec_base = (state == ACQUIRE) ? rec_q : '0;
    cur_cnt  = (state == ACQUIRE) ? skew_cnt : '0;
    rec_next = rec_base | rise;
    max_arr  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      arr_next[i] = (rise[i] && !rec_base[i]) ? cur_cnt : arr_q[i];
      if (arr_next[i] > max_arr) max_arr = arr_next[i];
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      dly_next[i] = max_arr - arr_next[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      skew_cnt   <= '0;
      rec_q      <= '0;
      arr_q      <= '{default: '0};
      delay_q    <= '{default: '0};
      locked     <= 1'b0;
      align_err  <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= '0;
    end else begin
      align_err  <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= '0;
      case (state)
        IDLE: begin
          if (|rise) begin
            rec_q    <= rise;
            arr_q    <= arr_next;
            skew_cnt <= SKEW_W'(1);
            if (&rise) begin
              delay_q <= dly_next;
              locked  <= 1'b1;
              state   <= LOCKED;
            end else begin
              state <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          skew_cnt <= skew_cnt + SKEW_W'(1);
          rec_q    <= rec_next;
          arr_q    <= arr_next;
          if (skew_cnt > SKEW_LIM) begin
            align_err <= 1'b1;
            state     <= DRAIN;
          end else if (&rec_next) begin
            delay_q <= dly_next;
            locked  <= 1'b1;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (&dly_valid) begin
            word_valid <= 1'b1;
            word_out   <= dly_data;
          end else if (~|dly_valid) begin
            locked  <= 1'b0;
            delay_q <= '{default: '0};
            state   <= IDLE;
          end else begin
            align_err <= 1'b1;
            locked    <= 1'b0;
            delay_q   <= '{default: '0};
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (~|lane_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LANE_DESKEW_STATS_EN
  logic locked_d;

  // Counters trail the event by one cycle; entry to LOCKED is the rise of locked.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      locked_d   <= 1'b0;
      lock_count <= '0;
      err_count  <= '0;
    end else begin
      locked_d <= locked;
      if (locked && !locked_d && lock_count != 16'hFFFF)
        lock_count <= lock_count + 16'd1;
      if (align_err && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/lane_deskew.md
LANE_DESKEW -- requirements
Module: lane_deskew

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, number of byte lanes (legal 1..4).
REQ-002 SHALL have parameter MAX_SKEW, default 2, largest tolerated inter-lane arrival skew in cycles (legal 0..7).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port lane_valid  input  NUM_LANES  per-lane HS valid; bit i = lane i.
REQ-006 SHALL have port lane_data  input  8*NUM_LANES  per-lane byte; lane i at [8i+7:8i].
REQ-007 SHALL have port word_out  output  8*NUM_LANES  aligned word; lane i at [8i+7:8i].
REQ-008 SHALL have port word_valid  output  1  word_out carries one aligned byte from every lane.
REQ-009 SHALL have port locked  output  1  per-lane delays captured and in use.
REQ-010 SHALL have port align_err  output  1  one-cycle pulse on skew overrun or desync.

Function
REQ-011 SHALL keep, per lane, a registered delay line of MAX_SKEW+1 taps carrying data and valid; tap 0 is input registered once.
REQ-012 SHALL run an FSM with states IDLE, ACQUIRE, LOCKED, DRAIN.
REQ-013 IDLE: on any lane's valid rising edge (0 at tap 0, 1 at input) SHALL record that lane's arrival as 0, start skew counter, go to ACQUIRE.
REQ-014 ACQUIRE: SHALL increment skew counter each cycle and record each further lane's arrival as the counter value at its rising edge.
REQ-015 Simultaneous rising edges SHALL record equal arrivals; a lane already recorded SHALL ignore further edges until IDLE.
REQ-016 When all lanes are recorded, SHALL set lane i delay = max_arrival - arrival_i and go to LOCKED next cycle.
REQ-017 If skew counter exceeds MAX_SKEW with any lane unrecorded, SHALL pulse align_err and go to DRAIN.
REQ-018 LOCKED: word_out lane i SHALL be registered from tap delay_i; word_valid SHALL be registered AND of delayed valids.
REQ-019 Latency SHALL be 2 cycles from the latest-arriving lane's input byte to word_out.
REQ-020 LOCKED: when all delayed valids are 0 in the same cycle, SHALL go to IDLE, deassert locked, clear delays.
REQ-021 LOCKED: if delayed valids disagree (some 0, some 1), SHALL pulse align_err, force word_valid 0, go to DRAIN.
REQ-022 DRAIN: SHALL wait until all raw lane_valid are 0, then go to IDLE.
REQ-023 word_valid SHALL be 0 outside LOCKED; word_out SHALL hold zero whenever word_valid is 0.
REQ-024 NUM_LANES=1 SHALL lock one cycle after the rising edge with delay 0.

Reset
REQ-025 resetn low SHALL asynchronously clear all taps, delays, counters and FSM to IDLE; word_out=0, word_valid=0, locked=0, align_err=0.
REQ-026 Reset mid-LOCKED SHALL drop word_valid immediately; re-lock SHALL require fresh rising edges on all lanes.

Configuration
REQ-027 With LANE_DESKEW_STATS_EN defined, SHALL add outputs lock_count[15:0] and err_count[15:0], saturating at 0xFFFF, incremented on each entry to LOCKED and each align_err pulse, cleared by reset.
REQ-028 Without LANE_DESKEW_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 State enum, SKEW_W width constant and lane byte width SHALL live in package lane_deskew_pkg.
REQ-030 Per-lane delay line with variable tap select SHALL be sub-module lane_delay_line, instantiated NUM_LANES times.

Verification
REQ-031 2 lanes, lane1 valid 2 cycles after lane0, bytes 0xA0.. / 0xB0.. -> locked, words {0xB0,0xA0},{0xB1,0xA1} in order, latency 2 from lane1.
REQ-032 4 lanes, arrivals 0,1,0,2 -> delays 2,1,2,0; every output word holds same byte index from all lanes.
REQ-033 2 lanes, MAX_SKEW=2, lane1 arrives 3 cycles late -> align_err one pulse, word_valid never 1, IDLE after both valids low.
REQ-034 Locked 2 lanes, lane0 valid drops 1 cycle before lane1 (no skew) -> align_err pulse, word_valid 0, DRAIN then IDLE.
REQ-035 resetn low mid-packet -> outputs 0 same cycle; next packet with skew 1 re-locks with correct delays.
REQ-036 With LANE_DESKEW_STATS_EN, 3 good packets + 1 skew overrun -> lock_count=3, err_count=1.
